// File: rtl/slc3_sram_bridge.sv
// slc3_sram_bridge: copies a ROM image into RAM after reset, then serves the SLC-3 SRAM bus (optional readback check: SLC3_SRAM_BRIDGE_VERIFY_EN)
module slc3_sram_bridge #(
  parameter int DEPTH_W    = 10,
  parameter int INIT_WORDS = 256,
  parameter int DATA_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [15:0]        ADDR,
  input  logic               OE,
  input  logic               WE,
  input  logic [DATA_W-1:0]  Data_to_SRAM,
  output logic [DATA_W-1:0]  Data_from_SRAM,
  output logic [DEPTH_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DEPTH_W-1:0] ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               ram_we,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic               cpu_hold,
  output logic               init_done,
  output logic               init_error
);
  typedef enum logic [1:0] {FILL, VERIFY, RUN} state_t;
  localparam logic [DEPTH_W-1:0] LAST = DEPTH_W'(INIT_WORDS - 1);
  state_t state;
  logic [DEPTH_W-1:0] rd_ptr, wr_addr;
  logic wr_valid, rd_ram, in_range, last_beat, mismatch;
  logic [DATA_W-1:0] dout_q;
  assign rom_addr  = rd_ptr;
  assign in_range  = (ADDR >> DEPTH_W) == 16'd0;
  assign last_beat = wr_valid && wr_addr == LAST;
`ifdef SLC3_SRAM_BRIDGE_VERIFY_EN
  assign mismatch  = state == VERIFY && wr_valid && rom_data != ram_rdata;
`else
  assign mismatch  = 1'b0;
`endif
  // RAM port mux: delayed copy stream in FILL, lockstep readback in VERIFY, CPU bus in RUN; reads held in the RAM output until captured
  always_comb begin
    ram_addr       = state == RUN ? ADDR[DEPTH_W-1:0] : state == VERIFY ? rd_ptr : wr_addr;
    ram_wdata      = state == RUN ? Data_to_SRAM : rom_data;
    ram_we         = state == RUN ? ~WE & in_range : state == FILL & wr_valid;
    Data_from_SRAM = rd_ram ? ram_rdata : dout_q;
  end
  // init sequencer plus CPU read-path registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= FILL;
      rd_ptr     <= '0;
      wr_addr    <= '0;
      wr_valid   <= 1'b0;
      cpu_hold   <= 1'b1;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      rd_ram     <= 1'b0;
      dout_q     <= '0;
    end else if (state != RUN) begin
      wr_valid <= ~last_beat;
      wr_addr  <= rd_ptr;
      rd_ptr   <= rd_ptr + DEPTH_W'(rd_ptr != LAST);
      if (mismatch) init_error <= 1'b1;
`ifdef SLC3_SRAM_BRIDGE_VERIFY_EN
      if (last_beat && state == FILL) begin
        state  <= VERIFY;
        rd_ptr <= '0;
      end else
`endif
      if (last_beat) begin
        state     <= RUN;
        init_done <= 1'b1;
        cpu_hold  <= init_error | mismatch;
      end
    end else if (!OE) begin
      rd_ram <= in_range & WE;
      dout_q <= in_range & ~WE ? Data_to_SRAM : '0;
    end else begin
      rd_ram <= 1'b0;
      if (rd_ram) dout_q <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_slc3_sram_bridge.sv
// tb_slc3_sram_bridge: randomized self-checking bench with ROM/RAM models and a word-level memory reference
module tb_slc3_sram_bridge;
  localparam int DW = 10;
  localparam int IW = 256;
`ifdef SLC3_SRAM_BRIDGE_VERIFY_EN
  localparam int DONE_EDGE = 2 * IW + 2;
`else
  localparam int DONE_EDGE = IW + 1;
`endif
  logic Clk = 1'b0, Reset = 1'b1, OE = 1'b1, WE = 1'b1;
  logic [15:0] ADDR = '0, Data_to_SRAM = '0, Data_from_SRAM, rom_data, ram_wdata, ram_rdata;
  logic [DW-1:0] rom_addr, ram_addr;
  logic ram_we, cpu_hold, init_done, init_error;
  logic corrupt_en = 1'b0;
  logic [15:0] rom [1024];
  logic [15:0] mem [1024];
  logic [15:0] exp_mem [1024];
  logic known [1024];
  logic [15:0] exp_dout;
  logic exp_known, exp_we, got_we;
  int checks = 0, failures = 0;

  slc3_sram_bridge #(.DEPTH_W(DW), .INIT_WORDS(IW), .DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .cpu_hold(cpu_hold), .init_done(init_done), .init_error(init_error));

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    rom_data  <= rom[rom_addr];
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= (corrupt_en && ram_addr == 10'd7) ? ram_wdata ^ 16'h0001 : ram_wdata;
  end

  task automatic step(input logic [15:0] a, input logic oe, input logic we, input logic [15:0] d);
    logic inr;
    ADDR = a; OE = oe; WE = we; Data_to_SRAM = d;
    inr = a < 16'd1024;
    exp_we = !we && inr;
    #1 got_we = ram_we;
    if (!oe) begin
      if (!inr) begin exp_dout = 16'h0000; exp_known = 1'b1; end
      else if (!we) begin exp_dout = d; exp_known = 1'b1; end
      else begin exp_dout = exp_mem[a]; exp_known = known[a]; end
    end
    if (exp_we) begin exp_mem[a] = d; known[a] = 1'b1; end
    @(posedge Clk); #1;
  endtask

  task automatic run_fill(input string tag);
    int we_cnt = 0, bad_addr = 0, hold_bad = 0, done_edge = -1, bad_words = 0;
    for (int e = 0; e < 3000 && done_edge < 0; e++) begin
      if (e > 0) begin @(posedge Clk); #1; end
      if (init_done) done_edge = e;
      else begin
        if (!cpu_hold || Data_from_SRAM !== 16'h0000) hold_bad++;
        if (ram_we) begin we_cnt++; if (ram_addr !== 10'(e - 1)) bad_addr++; end
      end
    end
    checks++; if (done_edge !== DONE_EDGE) begin failures++; $display("FAIL %s done_edge got=%0d exp=%0d", tag, done_edge, DONE_EDGE); end
    checks++; if (we_cnt !== IW) begin failures++; $display("FAIL %s we_cycles got=%0d exp=%0d", tag, we_cnt, IW); end
    checks++; if (bad_addr !== 0) begin failures++; $display("FAIL %s write_order bad=%0d exp=0", tag, bad_addr); end
    checks++; if (hold_bad !== 0) begin failures++; $display("FAIL %s hold_during_fill bad=%0d exp=0", tag, hold_bad); end
    checks++; if (cpu_hold !== 1'b0 || init_error !== 1'b0) begin failures++; $display("FAIL %s release got hold=%b err=%b exp 0 0", tag, cpu_hold, init_error); end
    for (int k = 0; k < IW; k++) if (mem[k] !== 16'hA000 + 16'(k)) bad_words++;
    checks++; if (bad_words !== 0) begin failures++; $display("FAIL %s image bad_words=%0d exp=0", tag, bad_words); end
    for (int k = 0; k < IW; k++) begin exp_mem[k] = 16'hA000 + 16'(k); known[k] = 1'b1; end
    exp_known = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({cpu_hold, init_done, init_error, ram_we} !== 4'b1000 || Data_from_SRAM !== 16'h0 || rom_addr !== '0) begin
      failures++;
      $display("FAIL reset_state got hold=%b done=%b err=%b we=%b dout=%h rom_addr=%h exp 1 0 0 0 0000 000",
               cpu_hold, init_done, init_error, ram_we, Data_from_SRAM, rom_addr);
    end
    Reset = 1'b0;
    run_fill("first_fill");
  endtask

  task automatic test_read;
    step(16'h0005, 1'b0, 1'b1, 16'h0);
    checks++; if (Data_from_SRAM !== 16'hA005) begin failures++; $display("FAIL read5 got=%h exp=a005", Data_from_SRAM); end
    for (int i = 0; i < 3; i++) begin
      step(16'($urandom), 1'b1, 1'b1, 16'($urandom));
      checks++; if (Data_from_SRAM !== 16'hA005) begin failures++; $display("FAIL read5_hold%0d got=%h exp=a005", i, Data_from_SRAM); end
    end
  endtask

  task automatic test_forward;
    step(16'h0010, 1'b0, 1'b0, 16'h1234);
    checks++; if (Data_from_SRAM !== 16'h1234 || got_we !== 1'b1) begin failures++; $display("FAIL fwd got=%h we=%b exp=1234 1", Data_from_SRAM, got_we); end
    step(16'h0010, 1'b1, 1'b1, 16'h0);
    step(16'h0010, 1'b0, 1'b1, 16'h0);
    checks++; if (Data_from_SRAM !== 16'h1234) begin failures++; $display("FAIL fwd_readback got=%h exp=1234", Data_from_SRAM); end
  endtask

  task automatic test_oob;
    step(16'h03FF, 1'b1, 1'b0, 16'h5A5A);
    step(16'hFFFF, 1'b1, 1'b0, 16'hBEEF);
    checks++; if (got_we !== 1'b0) begin failures++; $display("FAIL oob_we got=%b exp=0", got_we); end
    step(16'hFFFF, 1'b0, 1'b1, 16'h0);
    checks++; if (Data_from_SRAM !== 16'h0000) begin failures++; $display("FAIL oob_read got=%h exp=0000", Data_from_SRAM); end
    step(16'h03FF, 1'b0, 1'b1, 16'h0);
    checks++; if (Data_from_SRAM !== 16'h5A5A) begin failures++; $display("FAIL oob_no_alias got=%h exp=5a5a", Data_from_SRAM); end
  endtask

  task automatic test_random;
    logic [15:0] a;
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 511));
      step(a, 1'($urandom_range(0, 2) == 0 ? 1 : 0) ^ 1'b1 ^ 1'b1 ? 1'b1 : 1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom));
      checks++; if (got_we !== exp_we) begin failures++; $display("FAIL rand_we[%0d] addr=%h got=%b exp=%b", i, a, got_we, exp_we); end
      if (exp_known) begin
        checks++; if (Data_from_SRAM !== exp_dout) begin failures++; $display("FAIL rand_dout[%0d] addr=%h got=%h exp=%h", i, a, Data_from_SRAM, exp_dout); end
      end
    end
    OE = 1'b1; WE = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic found = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge Clk); #1;
      if (ram_we && ram_addr == 10'd100) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_reach_word100 got=0 exp=1"); end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checks++; if (rom_addr !== '0 || cpu_hold !== 1'b1 || init_done !== 1'b0) begin
      failures++; $display("FAIL mid_restart got rom_addr=%h hold=%b done=%b exp 000 1 0", rom_addr, cpu_hold, init_done);
    end
    run_fill("refill");
    step(16'h0010, 1'b0, 1'b1, 16'h0);
    checks++; if (Data_from_SRAM !== 16'hA010) begin failures++; $display("FAIL refill_overwrite got=%h exp=a010", Data_from_SRAM); end
    OE = 1'b1;
  endtask

`ifdef SLC3_SRAM_BRIDGE_VERIFY_EN
  task automatic test_verify_error;
    int done_edge = -1;
    corrupt_en = 1'b1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int e = 0; e < 3000 && done_edge < 0; e++) begin
      if (e > 0) begin @(posedge Clk); #1; end
      if (init_done) done_edge = e;
    end
    corrupt_en = 1'b0;
    checks++; if (done_edge !== DONE_EDGE) begin failures++; $display("FAIL verr_done_edge got=%0d exp=%0d", done_edge, DONE_EDGE); end
    checks++; if (init_error !== 1'b1 || cpu_hold !== 1'b1) begin failures++; $display("FAIL verr_flags got err=%b hold=%b exp 1 1", init_error, cpu_hold); end
    repeat (5) @(posedge Clk);
    #1;
    checks++; if (init_error !== 1'b1 || cpu_hold !== 1'b1 || init_done !== 1'b1) begin
      failures++; $display("FAIL verr_sticky got err=%b hold=%b done=%b exp 1 1 1", init_error, cpu_hold, init_done);
    end
  endtask
`else
  task automatic test_no_error;
    checks++; if (init_error !== 1'b0) begin failures++; $display("FAIL no_verify_error got=%b exp=0", init_error); end
  endtask
`endif

  initial begin
    for (int k = 0; k < 1024; k++) begin rom[k] = 16'hA000 + 16'(k); known[k] = 1'b0; exp_mem[k] = '0; end
    exp_known = 1'b0;
    test_reset;
    test_read;
    test_forward;
    test_oob;
    test_random;
    test_reset_mid;
`ifdef SLC3_SRAM_BRIDGE_VERIFY_EN
    test_verify_error;
`else
    test_no_error;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
